// File: rtl/clk_sel_pkg.sv
// ---------------------------------------------------------------------------
// clk_sel_pkg
// Shared types and default constants for the clock-select sequencer.
//   clk_sel_state_t : sequencer FSM state encoding
//   DEF_*           : default window / threshold / hold parameters
// ---------------------------------------------------------------------------
package clk_sel_pkg;

    typedef enum logic [2:0] {
        S_CLK1  = 3'd0,
        S_QUAL  = 3'd1,
        S_HOLD2 = 3'd2,
        S_CLK2  = 3'd3,
        S_HOLD1 = 3'd4
    } clk_sel_state_t;

    localparam int DEF_WIN_CYC   = 256;
    localparam int DEF_MIN_EDGES = 100;
    localparam int DEF_MAX_EDGES = 140;
    localparam int DEF_HOLD_CYC  = 16;

endpackage

// File: rtl/clk_toggle_mon.sv
// ---------------------------------------------------------------------------
// clk_toggle_mon
// Qualifies the asynchronous clk2/2 toggle by counting its edges over fixed
// clk1 windows.
// Ports:
//   clk, res     : clk1 and synchronous active-high reset
//   tgl          : clk2/2 toggle, asynchronous to clk
//   restart      : restart window and edge counter from zero
//   win_done     : high on the last cycle of each window
//   good         : window edge count within [MIN_EDGES, MAX_EDGES];
//                  only meaningful while win_done is high
//   cnt_latched  : edge count captured at the last window end
// ---------------------------------------------------------------------------
module clk_toggle_mon #(
    parameter int WIN_CYC   = 256,
    parameter int CNT_W     = 8,
    parameter int MIN_EDGES = 100,
    parameter int MAX_EDGES = 140
) (
    input  logic             clk,
    input  logic             res,
    input  logic             tgl,
    input  logic             restart,
    output logic             win_done,
    output logic             good,
    output logic [CNT_W-1:0] cnt_latched
);

    localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_EDGES);

    logic             sync1, sync2, sync3;
    logic             tgl_edge;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_sum;

    // sync1/sync2 resynchronize; sync3 is the edge-detect history flop
    assign tgl_edge = sync2 ^ sync3;
    assign win_done = (win_cnt == WIN_W'(WIN_CYC - 1));

    // Count including this cycle's edge, saturating at all-ones
    assign cnt_sum = (tgl_edge && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
    assign good    = (cnt_sum >= MIN_V) && (cnt_sum <= MAX_V);

    always_ff @(posedge clk) begin
        if (res) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            win_cnt     <= '0;
            cnt         <= '0;
            cnt_latched <= '0;
        end else begin
            sync1 <= tgl;
            sync2 <= sync1;
            sync3 <= sync2;
            // After a window end cnt starts from 0, so an edge in the
            // following cycle naturally makes it 1.
            if (restart || win_done) begin
                win_cnt <= '0;
                cnt     <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                cnt     <= cnt_sum;
            end
            if (win_done)
                cnt_latched <= cnt_sum;
        end
    end

endmodule

// File: rtl/clk_sel_ctrl.sv
// ---------------------------------------------------------------------------
// clk_sel_ctrl
// Clock-select sequencer (clk1 domain) driving sel of a glitch-free clock
// mux. Switches to clk2 only after QUAL_WIN consecutive good windows and
// holds sel for HOLD_CYC cycles after every change.
// Ports:
//   clk1, clk1_res : clock and synchronous active-high reset
//   clk2_tgl       : clk2/2 toggle (asynchronous)
//   req_clk2       : level request to run from clk2
//   fail_clr       : pulse clearing fail_sticky (a same-cycle set wins)
//   sel            : registered mux select, 0 = clk1, 1 = clk2
//   busy           : high in S_QUAL, S_HOLD2, S_HOLD1
//   clk2_ok        : result of the last completed window
//   fail_sticky    : clk2 went bad while selected
//   edge_cnt       : edge count latched at the last window end
// Configuration macro: CLK_SEL_AUTO_FAILBACK_EN
//   defined   -> bad window in S_CLK2 fails back to clk1 via S_HOLD1
//   undefined -> bad window in S_CLK2 only flags, sel stays 1
// ---------------------------------------------------------------------------
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int WIN_CYC   = DEF_WIN_CYC,
    parameter int CNT_W     = 8,
    parameter int MIN_EDGES = DEF_MIN_EDGES,
    parameter int MAX_EDGES = DEF_MAX_EDGES,
    parameter int QUAL_WIN  = 2,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic             clk1,
    input  logic             clk1_res,
    input  logic             clk2_tgl,
    input  logic             req_clk2,
    input  logic             fail_clr,
    output logic             sel,
    output logic             busy,
    output logic             clk2_ok,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int HOLD_W = $clog2(HOLD_CYC);
    localparam int RUN_W  = (QUAL_WIN > 1) ? $clog2(QUAL_WIN + 1) : 1;

    clk_sel_state_t    state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RUN_W-1:0]  good_run;
    logic              restart;
    logic              win_done;
    logic              good;
    logic              hold_last;
    logic              fail_set;
    logic              sel_nxt;

    clk_toggle_mon #(
        .WIN_CYC   (WIN_CYC),
        .CNT_W     (CNT_W),
        .MIN_EDGES (MIN_EDGES),
        .MAX_EDGES (MAX_EDGES)
    ) u_mon (
        .clk         (clk1),
        .res         (clk1_res),
        .tgl         (clk2_tgl),
        .restart     (restart),
        .win_done    (win_done),
        .good        (good),
        .cnt_latched (edge_cnt)
    );

    assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYC - 1));
    assign fail_set  = (state == S_CLK2) && win_done && !good;
    assign busy      = (state == S_QUAL) || (state == S_HOLD2) || (state == S_HOLD1);

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            S_CLK1: begin
                if (req_clk2) begin
                    state_nxt = S_QUAL;
                    restart   = 1'b1;
                end
            end
            S_QUAL: begin
                if (!req_clk2)
                    state_nxt = S_CLK1;
                else if (win_done && good && (good_run == RUN_W'(QUAL_WIN - 1)))
                    state_nxt = S_HOLD2;
            end
            S_HOLD2: begin
                if (hold_last)
                    state_nxt = S_CLK2;
            end
            S_CLK2: begin
`ifdef CLK_SEL_AUTO_FAILBACK_EN
                if (!req_clk2 || fail_set)
                    state_nxt = S_HOLD1;
`else
                if (!req_clk2)
                    state_nxt = S_HOLD1;
`endif
            end
            S_HOLD1: begin
                if (hold_last)
                    state_nxt = S_CLK1;
            end
            default: state_nxt = S_CLK1;
        endcase
    end

    // sel is its own flop so the mux never sees decode glitches
    assign sel_nxt = (state_nxt == S_HOLD2) || (state_nxt == S_CLK2);

    always_ff @(posedge clk1) begin
        if (clk1_res) begin
            state       <= S_CLK1;
            sel         <= 1'b0;
            hold_cnt    <= '0;
            good_run    <= '0;
            clk2_ok     <= 1'b0;
            fail_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;

            // Hold counter restarts on every state change
            if (state_nxt != state)
                hold_cnt <= '0;
            else if ((state == S_HOLD2) || (state == S_HOLD1))
                hold_cnt <= hold_cnt + HOLD_W'(1);

            if (restart)
                good_run <= '0;
            else if ((state == S_QUAL) && win_done)
                good_run <= good ? good_run + RUN_W'(1) : '0;

            if (win_done)
                clk2_ok <= good;

            if (fail_set)
                fail_sticky <= 1'b1;
            else if (fail_clr)
                fail_sticky <= 1'b0;
        end
    end

endmodule
